// File: rtl/irq_ctrl.sv
// MSP430-style interrupt controller: synchronizes and edge-detects IRQ/NMI lines, holds pending flags,
// arbitrates (NMI first, then highest index) and tracks the request/service handshake with instr_dec.
module irq_ctrl #(
  parameter int NUM_IRQ = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic [NUM_IRQ-1:0] IE,
  input  logic               GIE,
  input  logic [NUM_IRQ-1:0] IFG_clr,
  input  logic               IRQ_ack,
  input  logic               RETI,
  output logic               IRQ_req,
  output logic [15:0]        IRQ_vec,
  output logic [NUM_IRQ-1:0] IFG,
  output logic               NMI_IFG,
  output logic               IRQ_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;

  localparam logic [15:0] VEC_BASE = 16'hFFE0;
  localparam logic [15:0] VEC_NMI  = 16'hFFFC;

  logic [1:0]         state, state_nxt;
  logic [NUM_IRQ-1:0] irq_s1, irq_s2, irq_d;
  logic               nmi_s1, nmi_s2, nmi_d;
  logic [NUM_IRQ-1:0] irq_edge;
  logic               nmi_edge;

  logic [NUM_IRQ-1:0] elig;
  logic               any_elig;
  logic [3:0]         win_idx;
  logic [15:0]        win_vec;

  logic               lat_nmi;
  logic [3:0]         lat_idx;
  logic               lat_elig;
  logic               grant;
  logic [NUM_IRQ-1:0] grant_clr;

  assign irq_edge = irq_s2 & ~irq_d;
  assign nmi_edge = nmi_s2 & ~nmi_d;

  assign elig     = IFG & IE & {NUM_IRQ{GIE}};
  assign any_elig = NMI_IFG | (|elig);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    win_idx = 4'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i]) win_idx = i[3:0];
    end
    win_vec = NMI_IFG ? VEC_NMI : (VEC_BASE + {11'd0, win_idx, 1'b0});
  end

  assign lat_elig = lat_nmi ? NMI_IFG : (IFG[lat_idx] & IE[lat_idx] & GIE);
  assign grant    = (state == S_REQ) & IRQ_ack;

  always_comb begin
    grant_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      grant_clr[i] = grant & ~lat_nmi & (lat_idx == i[3:0]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_elig) state_nxt = S_REQ;
      // The grant is checked first so an ack that coincides with a withdraw still completes.
      S_REQ: begin
        if (IRQ_ack)       state_nxt = S_SERV;
        else if (!lat_elig) state_nxt = S_IDLE;
      end
      S_SERV: if (RETI) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_s1  <= '0;
      irq_s2  <= '0;
      irq_d   <= '0;
      nmi_s1  <= 1'b0;
      nmi_s2  <= 1'b0;
      nmi_d   <= 1'b0;
      IFG     <= '0;
      NMI_IFG <= 1'b0;
      state   <= S_IDLE;
      lat_nmi <= 1'b0;
      lat_idx <= 4'd0;
      IRQ_vec <= 16'h0000;
    end else begin
      irq_s1  <= irq_in;
      irq_s2  <= irq_s1;
      irq_d   <= irq_s2;
      nmi_s1  <= nmi_in;
      nmi_s2  <= nmi_s1;
      nmi_d   <= nmi_s2;
      // A fresh edge beats any clear landing on the same bit.
      IFG     <= irq_edge | (IFG & ~(IFG_clr | grant_clr));
      NMI_IFG <= nmi_edge | (NMI_IFG & ~(grant & lat_nmi));
      state   <= state_nxt;
      if (state == S_IDLE && any_elig) begin
        lat_nmi <= NMI_IFG;
        lat_idx <= win_idx;
        IRQ_vec <= win_vec;
      end
    end
  end

  assign IRQ_req  = (state == S_REQ);
  assign IRQ_busy = (state == S_SERV);

endmodule
